// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute over 3-5 states and
// drives the ALU operation code plus datapath enables and mux selects.
module multicycle_control #(
  parameter bit MEM_WAIT_EN = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic [3:0] ALUOperation,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtZero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC_R    = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_EXEC_I    = 4'd10,
    S_ILLEGAL   = 4'd15
  } state_t;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_NOR  = 4'b0010;
  localparam logic [3:0] ALU_ADD  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_SLL  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_LUI  = 4'b0111;
  localparam logic [3:0] ALU_ORI  = 4'b1001;
  localparam logic [3:0] ALU_ADDI = 4'b1010;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  state_t state, next_state;
  logic   mem_rdy;
  logic [3:0] r_op, i_op;
  logic   r_ok, i_ext;
  logic   pc_write, mem_read, mem_write, ir_write, reg_write;

  assign mem_rdy = MEM_WAIT_EN ? MemReady : 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Execute-stage decode, shared by EXEC_* and ALU_WB so ALU_WB holds the same controls.
  always_comb begin
    r_op = ALU_ADD;
    r_ok = 1'b1;
    case (Funct)
      6'b100000: r_op = ALU_ADD;
      6'b100010: r_op = ALU_SUB;
      6'b100100: r_op = ALU_AND;
      6'b100101: r_op = ALU_OR;
      6'b100111: r_op = ALU_NOR;
      6'b000000: r_op = ALU_SLL;
      6'b000010: r_op = ALU_SRL;
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    i_op  = ALU_ADD;
    i_ext = 1'b0;
    case (Opcode)
      OP_ADDI: i_op = ALU_ADDI;
      OP_ANDI: begin i_op = ALU_AND; i_ext = 1'b1; end
      OP_ORI:  begin i_op = ALU_ORI; i_ext = 1'b1; end
      OP_LUI:  begin i_op = ALU_LUI; i_ext = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    next_state   = state;
    ALUOperation = ALU_ADD;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ExtZero      = 1'b0;
    PCSource     = 2'b00;
    IorD         = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    pc_write     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    reg_write    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = 2'b01;
        if (mem_rdy) begin
          ir_write   = 1'b1;
          pc_write   = 1'b1;
          next_state = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_RTYPE:                         next_state = S_EXEC_R;
          OP_LW, OP_SW:                     next_state = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   next_state = S_BRANCH;
          OP_J:                             next_state = S_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: next_state = S_EXEC_I;
          default:                          next_state = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        next_state = (Opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
        if (mem_rdy) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        MemtoReg   = 1'b1;
        next_state = S_FETCH;
      end
      S_MEM_WRITE: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
        if (mem_rdy) next_state = S_FETCH;
      end
      S_EXEC_R: begin
        ALUSrcA      = 1'b1;
        ALUOperation = r_op;
        next_state   = r_ok ? S_ALU_WB : S_ILLEGAL;
      end
      S_EXEC_I: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = i_op;
        ExtZero      = i_ext;
        next_state   = S_ALU_WB;
      end
      S_ALU_WB: begin
        reg_write  = 1'b1;
        ALUSrcA    = 1'b1;
        next_state = S_FETCH;
        if (Opcode == OP_RTYPE) begin
          RegDst       = 1'b1;
          ALUOperation = r_op;
        end else begin
          ALUSrcB      = 2'b10;
          ALUOperation = i_op;
          ExtZero      = i_ext;
        end
      end
      S_BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSource     = 2'b01;
        pc_write     = (Opcode == OP_BNE) ? ~Zero : Zero;
        next_state   = S_FETCH;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        PCSource   = 2'b10;
        next_state = S_FETCH;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_ILLEGAL;
    endcase
  end

  // Enables are gated by reset directly so a mid-cycle abort drops them at once.
  assign PCWrite  = pc_write  & reset;
  assign MemRead  = mem_read  & reset;
  assign MemWrite = mem_write & reset;
  assign IRWrite  = ir_write  & reset;
  assign RegWrite = reg_write & reset;
  assign Illegal  = (state == S_ILLEGAL);
  assign State    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver pushes one expected output vector
// per cycle and a negedge monitor pops and compares it.
module tb_multicycle_control;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic [3:0] ALUOperation;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       ExtZero, PCWrite;
  logic [1:0] PCSource;
  logic       IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Illegal;
  logic [3:0] State;

  multicycle_control #(.MEM_WAIT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .ALUOperation(ALUOperation), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtZero(ExtZero), .PCWrite(PCWrite), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .Illegal(Illegal),
    .State(State)
  );

  // Vector layout: {aluop, srca, srcb, extz, pcw, pcsrc, iord, mrd, mwr, irw, rgw, rdst, m2r, ill, state}
  logic [22:0] act_vec;
  assign act_vec = {ALUOperation, ALUSrcA, ALUSrcB, ExtZero, PCWrite, PCSource, IorD,
                    MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, Illegal, State};

  localparam logic [22:0] V_RESET  = {4'b0011,1'b0,2'b01,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0};
  localparam logic [22:0] V_F_RDY  = {4'b0011,1'b0,2'b01,1'b0,1'b1,2'b00,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,4'd0};
  localparam logic [22:0] V_F_WAIT = {4'b0011,1'b0,2'b01,1'b0,1'b0,2'b00,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd0};
  localparam logic [22:0] V_DEC    = {4'b0011,1'b0,2'b11,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd1};
  localparam logic [22:0] V_EXR_SUB= {4'b0100,1'b1,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd6};
  localparam logic [22:0] V_WB_SUB = {4'b0100,1'b1,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,4'd7};
  localparam logic [22:0] V_MADDR  = {4'b0011,1'b1,2'b10,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd2};
  localparam logic [22:0] V_MRD    = {4'b0011,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd3};
  localparam logic [22:0] V_MWB    = {4'b0011,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,4'd4};
  localparam logic [22:0] V_MWR    = {4'b0011,1'b0,2'b00,1'b0,1'b0,2'b00,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,4'd5};
  localparam logic [22:0] V_BR_TK  = {4'b0100,1'b1,2'b00,1'b0,1'b1,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd8};
  localparam logic [22:0] V_BR_NT  = {4'b0100,1'b1,2'b00,1'b0,1'b0,2'b01,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd8};
  localparam logic [22:0] V_EXI_ORI= {4'b1001,1'b1,2'b10,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd10};
  localparam logic [22:0] V_WB_ORI = {4'b1001,1'b1,2'b10,1'b1,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,4'd7};
  localparam logic [22:0] V_JMP    = {4'b0011,1'b0,2'b00,1'b0,1'b1,2'b10,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd9};
  localparam logic [22:0] V_EXR_BAD= {4'b0011,1'b1,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,4'd6};
  localparam logic [22:0] V_ILL    = {4'b0011,1'b0,2'b00,1'b0,1'b0,2'b00,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,4'd15};

  logic [22:0] exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          vec_idx = 0;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int idx, input logic [22:0] act, input logic [22:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s #%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  // driver: apply inputs for one cycle and queue that cycle's expected outputs
  task automatic cyc(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic z, input logic mr, input logic [22:0] exp);
    @(posedge clk);
    #1;
    reset    = rst;
    Opcode   = op;
    Funct    = fn;
    Zero     = z;
    MemReady = mr;
    exp_q.push_back(exp);
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      check("out_vec", vec_idx, act_vec, exp_q.pop_front());
      vec_idx++;
    end
  end

  initial begin
    reset = 1'b0; Opcode = 6'd0; Funct = 6'd0; Zero = 1'b0; MemReady = 1'b1;

    // reset held three cycles, then first fetch
    for (int i = 0; i < 3; i++) cyc(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, V_RESET);

    // sub: 0,1,6,7
    cyc(1'b1, 6'h00, 6'b100010, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'h00, 6'b100010, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'h00, 6'b100010, 1'b0, 1'b1, V_EXR_SUB);
    cyc(1'b1, 6'h00, 6'b100010, 1'b0, 1'b1, V_WB_SUB);

    // lw with two wait cycles in MEM_READ: 0,1,2,3,3,3,4
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b1, V_MADDR);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b0, V_MRD);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b0, V_MRD);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b1, V_MRD);
    cyc(1'b1, 6'b100011, 6'h00, 1'b0, 1'b1, V_MWB);

    // beq taken, bne not taken (Zero=1 for both)
    cyc(1'b1, 6'b000100, 6'h00, 1'b1, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b000100, 6'h00, 1'b1, 1'b1, V_DEC);
    cyc(1'b1, 6'b000100, 6'h00, 1'b1, 1'b1, V_BR_TK);
    cyc(1'b1, 6'b000101, 6'h00, 1'b1, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b000101, 6'h00, 1'b1, 1'b1, V_DEC);
    cyc(1'b1, 6'b000101, 6'h00, 1'b1, 1'b1, V_BR_NT);

    // ori: ALU op and zero-extend held into ALU_WB
    cyc(1'b1, 6'b001101, 6'h00, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b001101, 6'h00, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'b001101, 6'h00, 1'b0, 1'b1, V_EXI_ORI);
    cyc(1'b1, 6'b001101, 6'h00, 1'b0, 1'b1, V_WB_ORI);

    // j
    cyc(1'b1, 6'b000010, 6'h00, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b000010, 6'h00, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'b000010, 6'h00, 1'b0, 1'b1, V_JMP);

    // sw with one fetch wait, reset asserted mid MEM_WRITE cycle
    cyc(1'b1, 6'b101011, 6'h00, 1'b0, 1'b0, V_F_WAIT);
    cyc(1'b1, 6'b101011, 6'h00, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b101011, 6'h00, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'b101011, 6'h00, 1'b0, 1'b1, V_MADDR);
    cyc(1'b1, 6'b101011, 6'h00, 1'b0, 1'b1, V_MWR);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_memwrite", 0, {18'd0, MemWrite, State}, 23'd0);
    cyc(1'b0, 6'b101011, 6'h00, 1'b0, 1'b1, V_RESET);
    cyc(1'b0, 6'b101011, 6'h00, 1'b0, 1'b1, V_RESET);

    // illegal opcode 111111: terminal
    cyc(1'b1, 6'b111111, 6'h00, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'b111111, 6'h00, 1'b0, 1'b1, V_DEC);
    for (int i = 0; i < 10; i++) cyc(1'b1, 6'b111111, 6'h00, 1'b0, 1'b1, V_ILL);

    // reset clears Illegal; then R-type with unsupported Funct
    cyc(1'b0, 6'h00, 6'b001000, 1'b0, 1'b1, V_RESET);
    cyc(1'b0, 6'h00, 6'b001000, 1'b0, 1'b1, V_RESET);
    cyc(1'b1, 6'h00, 6'b001000, 1'b0, 1'b1, V_F_RDY);
    cyc(1'b1, 6'h00, 6'b001000, 1'b0, 1'b1, V_DEC);
    cyc(1'b1, 6'h00, 6'b001000, 1'b0, 1'b1, V_EXR_BAD);
    for (int i = 0; i < 10; i++) cyc(1'b1, 6'h00, 6'b001000, 1'b0, 1'b1, V_ILL);

    // drain scoreboard, bounded
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("queue_drained", 0, 23'(exp_q.size()), 23'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
